// File: rtl/score_bcd_converter_pkg.sv
// Shared definitions for the score binary-to-BCD converter: default score
// geometry and the converter FSM state encoding.
package score_bcd_converter_pkg;

  localparam int SCORE_WIDTH  = 13;
  localparam int SCORE_DIGITS = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } convState_t;

endpackage

// File: rtl/score_bcd_converter_if.sv
// Start/result bundle between the score read port (master side) and the
// BCD converter (slave side) feeding the seven-segment screens.
interface score_bcd_converter_if
  import score_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = SCORE_WIDTH,
  parameter int DIGITS = SCORE_DIGITS
);

  logic              start;
  logic [WIDTH-1:0]  binIn;
  logic              busy;
  logic              done;
  logic [3:0]        digit0;
  logic [3:0]        digit1;
  logic [3:0]        digit2;
  logic [3:0]        digit3;
  logic [DIGITS-1:0] blank;

  modport master (
    output start,
    output binIn,
    input  busy,
    input  done,
    input  digit0,
    input  digit1,
    input  digit2,
    input  digit3,
    input  blank
  );

  modport slave (
    input  start,
    input  binIn,
    output busy,
    output done,
    output digit0,
    output digit1,
    output digit2,
    output digit3,
    output blank
  );

endinterface

// File: rtl/score_bcd_converter_bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next decade.
module bcd_add3_digit (
  input  logic [3:0] digitIn,
  output logic [3:0] digitOut
);

  assign digitOut = (digitIn >= 4'd5) ? (digitIn + 4'd3) : digitIn;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter for the reaction-time score. A start in
// IDLE latches the operand; WIDTH shift-and-add-3 steps follow, then the
// digits and leading-zero blank flags are loaded together with a Done pulse.
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = SCORE_WIDTH,
  parameter int DIGITS = SCORE_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  score_bcd_converter_if.slave  bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WIDTH);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  convState_t        state;
  convState_t        stateNext;
  logic [CNT_W-1:0]  count;
  logic [WIDTH-1:0]  operand;
  logic [WIDTH-1:0]  operandNext;
  logic [SCR_W-1:0]  scratch;
  logic [SCR_W-1:0]  scratchAdj;
  logic [SCR_W-1:0]  scratchNext;
  logic [SCR_W-1:0]  digitsOut;
  logic [DIGITS-1:0] blankOut;
  logic              doneReg;
  logic              accept;
  logic              lastShift;

  // Blank[i] is set while digit i and every more significant digit are zero;
  // the ones digit is never blanked so a zero score still shows "0".
  function automatic logic [DIGITS-1:0] leadZeroBlank(input logic [SCR_W-1:0] bcd);
    logic [DIGITS-1:0] flags;
    logic              allZero;
    flags   = '0;
    allZero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allZero  = allZero && (bcd[4*i +: 4] == 4'd0);
      flags[i] = allZero;
    end
    return flags;
  endfunction

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : gAdd3
      bcd_add3_digit uAdd3 (
        .digitIn  (scratch[4*g +: 4]),
        .digitOut (scratchAdj[4*g +: 4])
      );
    end
  endgenerate

  // One double-dabble step: corrected scratch and operand shift left as one word.
  assign {scratchNext, operandNext} = {scratchAdj, operand} << 1;

  assign accept    = (state == IDLE) && bus.start;
  assign lastShift = (state == SHIFT) && (count == CNT_ONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: start is only honoured in IDLE, so a start during a
  // conversion is dropped rather than queued.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = SHIFT;
      SHIFT:   if (count == CNT_ONE) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand, scratch and step counter; the operand is captured only on the
  // accepting edge so BinIn may change freely while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand <= '0;
      scratch <= '0;
      count   <= '0;
    end else if (accept) begin
      operand <= bus.binIn;
      scratch <= '0;
      count   <= CNT_LOAD;
    end else if (state == SHIFT) begin
      operand <= operandNext;
      scratch <= scratchNext;
      count   <= count - CNT_ONE;
    end
  end

  // Result registers load only on the final step, so the screens keep the
  // previous score for the whole conversion and update atomically with Done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digitsOut <= '0;
      blankOut  <= BLANK_RST;
      doneReg   <= 1'b0;
    end else begin
      doneReg <= lastShift;
      if (lastShift) begin
        digitsOut <= scratchNext;
        blankOut  <= leadZeroBlank(scratchNext);
      end
    end
  end

  assign bus.busy   = (state == SHIFT);
  assign bus.done   = doneReg;
  assign bus.digit0 = digitsOut[3:0];
  assign bus.digit1 = digitsOut[7:4];
  assign bus.digit2 = digitsOut[11:8];
  assign bus.digit3 = digitsOut[15:12];
  assign bus.blank  = blankOut;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: directed scenarios plus a
// random sweep, compared against a decimal reference model.
module tb_score_bcd_converter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  score_bcd_converter_if bus ();

  score_bcd_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits by plain division.
  function automatic logic [15:0] expBcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] expBlank(input int v);
    return {v < 1000, v < 100, v < 10, 1'b0};
  endfunction

  function automatic logic [15:0] gotBcd();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  // Every digit shown on a screen must be a legal decimal digit.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.digit0 > 4'd9 || bus.digit1 > 4'd9 || bus.digit2 > 4'd9 || bus.digit3 > 4'd9) begin
        errors++;
        $display("FAIL digit_range: got %h, required every digit <= 9", gotBcd());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start, then wait (bounded) for Done. lat = edges from accept to Done.
  task automatic runConv(input int v, output int lat, output int busyCnt, output logic doneAtAccept);
    bus.binIn = 13'(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    doneAtAccept = bus.done;
    lat = 0;
    busyCnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busyCnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.binIn = '0;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done, gotBcd(), bus.blank} !== {1'b0, 1'b0, 16'h0000, 4'b1110}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b digits=%h blank=%b, required 0 0 0000 1110",
               bus.busy, bus.done, gotBcd(), bus.blank);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat, bc;
    logic da;
    runConv(0, lat, bc, da);
    checks++;
    if (lat !== 13) begin
      errors++;
      $display("FAIL zero_latency: got %0d, required 13", lat);
    end
    checks++;
    if ({gotBcd(), bus.blank} !== {16'h0000, 4'b1110}) begin
      errors++;
      $display("FAIL zero_value: got %h blank=%b, required 0000 blank=1110", gotBcd(), bus.blank);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b one cycle later, required 0", bus.done);
    end
  endtask

  task automatic test_max();
    int lat, bc;
    logic da;
    runConv(8191, lat, bc, da);
    checks++;
    if ({gotBcd(), bus.blank} !== {16'h8191, 4'b0000}) begin
      errors++;
      $display("FAIL max_value: got %h blank=%b, required 8191 blank=0000", gotBcd(), bus.blank);
    end
    checks++;
    if (bc !== 13 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL max_busy_cycles: got %0d busy=%b at done, required 13 busy=0", bc, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bc;
    logic da;
    runConv(1234, lat1, bc, da);
    checks++;
    if ({gotBcd(), bus.blank} !== {16'h1234, 4'b0000} || lat1 !== 13) begin
      errors++;
      $display("FAIL b2b_first: got %h blank=%b lat=%0d, required 1234 blank=0000 lat=13",
               gotBcd(), bus.blank, lat1);
    end
    runConv(47, lat2, bc, da);
    checks++;
    if (da !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_drop: got done=%b after second accept, required 0", da);
    end
    checks++;
    if ({gotBcd(), bus.blank} !== {16'h0047, 4'b1100} || lat2 !== 13) begin
      errors++;
      $display("FAIL b2b_second: got %h blank=%b lat=%0d, required 0047 blank=1100 lat=13",
               gotBcd(), bus.blank, lat2);
    end
  endtask

  task automatic test_ignore_busy();
    int doneCnt = 0;
    int doneEdge = -1;
    logic [15:0] midDigits = 16'hFFFF;
    bus.binIn = 13'd250;
    bus.start = 1'b1;
    tick();
    bus.binIn = 13'd999;
    for (int e = 1; e <= 30; e++) begin
      bus.start = (e == 3 || e == 7);
      tick();
      bus.start = 1'b0;
      if (e == 6) midDigits = gotBcd();
      if (bus.done) begin
        doneCnt++;
        doneEdge = e;
      end
    end
    checks++;
    if (midDigits !== 16'h0047) begin
      errors++;
      $display("FAIL hold_during_busy: got %h mid-conversion, required previous 0047", midDigits);
    end
    checks++;
    if (doneCnt !== 1 || doneEdge !== 13) begin
      errors++;
      $display("FAIL ignore_start_done: got %0d pulses last at %0d, required 1 at 13", doneCnt, doneEdge);
    end
    checks++;
    if ({gotBcd(), bus.blank} !== {16'h0250, 4'b1000}) begin
      errors++;
      $display("FAIL ignore_start_value: got %h blank=%b, required 0250 blank=1000", gotBcd(), bus.blank);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    logic da;
    logic sawDone = 1'b0;
    bus.binIn = 13'd5000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, gotBcd(), bus.blank} !== {1'b0, 1'b0, 16'h0000, 4'b1110}) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b digits=%h blank=%b, required 0 0 0000 1110",
               bus.busy, bus.done, gotBcd(), bus.blank);
    end
    repeat (2) begin
      tick();
      if (bus.done) sawDone = 1'b1;
    end
    rst = 1'b0;
    repeat (15) begin
      tick();
      if (bus.done) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done pulse after abort, required none");
    end
    runConv(5000, lat, bc, da);
    checks++;
    if ({gotBcd(), bus.blank} !== {16'h5000, 4'b0000} || lat !== 13) begin
      errors++;
      $display("FAIL abort_recover: got %h blank=%b lat=%0d, required 5000 blank=0000 lat=13",
               gotBcd(), bus.blank, lat);
    end
  endtask

  task automatic test_sweep();
    int vals[$] = '{9, 10, 99, 100, 999, 1000, 4095, 8190};
    int lat, bc;
    logic da;
    repeat (40) vals.push_back(int'($urandom_range(0, 8191)));
    foreach (vals[k]) begin
      runConv(vals[k], lat, bc, da);
      checks++;
      if ({gotBcd(), bus.blank} !== {expBcd(vals[k]), expBlank(vals[k])} || lat !== 13) begin
        errors++;
        $display("FAIL sweep_%0d: got %h blank=%b lat=%0d, required %h blank=%b lat=13",
                 vals[k], gotBcd(), bus.blank, lat, expBcd(vals[k]), expBlank(vals[k]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
